// File: rtl/jpeg_mcu_sequencer_if.sv
// Handshake bundle between the MCU sequencer (master) and the MCU pipeline / marker writer (slave).
// Restart-marker signals exist only when JPEG_RESTART_EN is defined.
interface jpeg_mcu_sequencer_if #(
  parameter int MCU_BITS = 8
`ifdef JPEG_RESTART_EN
  , parameter int RI_BITS = 16
`endif
);
  logic                go;
  logic [MCU_BITS-1:0] mcu_cols;
  logic [MCU_BITS-1:0] mcu_rows;
  logic                mcu_req;
  logic                mcu_ack;
  logic [MCU_BITS-1:0] mcu_x;
  logic [MCU_BITS-1:0] mcu_y;
  logic                mcu_done;
  logic                busy;
  logic                frame_done;
  logic                go_drop;
`ifdef JPEG_RESTART_EN
  logic [RI_BITS-1:0]  ri;
  logic                rstm_req;
  logic                rstm_ack;
  logic [2:0]          rstm_idx;
`endif

  modport master (
    input  go, mcu_cols, mcu_rows, mcu_ack, mcu_done,
    output mcu_req, mcu_x, mcu_y, busy, frame_done, go_drop
`ifdef JPEG_RESTART_EN
    , input ri, rstm_ack
    , output rstm_req, rstm_idx
`endif
  );

  modport slave (
    output go, mcu_cols, mcu_rows, mcu_ack, mcu_done,
    input  mcu_req, mcu_x, mcu_y, busy, frame_done, go_drop
`ifdef JPEG_RESTART_EN
    , output ri, rstm_ack
    , input  rstm_req, rstm_idx
`endif
  );
endinterface

// File: rtl/jpeg_mcu_sequencer.sv
// Frame-level raster MCU scheduler: go -> req/ack per MCU -> wait done -> frame_done.
// Define JPEG_RESTART_EN to build restart-interval marker requests (RSTM state).
module jpeg_mcu_sequencer #(
  parameter int MCU_BITS = 8
`ifdef JPEG_RESTART_EN
  , parameter int RI_BITS = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  jpeg_mcu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
`ifdef JPEG_RESTART_EN
    RSTM      = 3'd3,
`endif
    FINISH    = 3'd4
  } state_e;

  localparam logic [MCU_BITS-1:0] M_ZERO = {MCU_BITS{1'b0}};
  localparam logic [MCU_BITS-1:0] M_ONE  = {{(MCU_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [MCU_BITS-1:0] cols_q, cols_d, rows_q, rows_d;
  logic [MCU_BITS-1:0] x_q, x_d, y_q, y_d;
  logic                req_q, req_d, busy_q, busy_d, fd_q, fd_d, drop_q, drop_d;
  logic                last_s;
`ifdef JPEG_RESTART_EN
  localparam logic [RI_BITS-1:0] R_ZERO = {RI_BITS{1'b0}};
  localparam logic [RI_BITS-1:0] R_ONE  = {{(RI_BITS-1){1'b0}}, 1'b1};
  logic [RI_BITS-1:0]  ri_q, ri_d, cnt_q, cnt_d;
  logic                rstm_req_q, rstm_req_d;
  logic [2:0]          rstm_idx_q, rstm_idx_d;
`endif

  assign last_s = (x_q == cols_q) && (y_q == rows_q);

  // Next-state and next-output logic; registered outputs follow the next state.
  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    x_d     = x_q;
    y_d     = y_q;
    req_d   = 1'b0;
    busy_d  = 1'b0;
    fd_d    = 1'b0;
    drop_d  = 1'b0;
`ifdef JPEG_RESTART_EN
    ri_d       = ri_q;
    cnt_d      = cnt_q;
    rstm_req_d = 1'b0;
    rstm_idx_d = rstm_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          cols_d  = bus.mcu_cols;
          rows_d  = bus.mcu_rows;
          x_d     = M_ZERO;
          y_d     = M_ZERO;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
`ifdef JPEG_RESTART_EN
          ri_d       = bus.ri;
          cnt_d      = R_ZERO;
          rstm_idx_d = 3'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        drop_d = bus.go;
        if (bus.mcu_ack) begin
          state_d = WAIT_DONE;
        end else begin
          req_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        busy_d = 1'b1;
        drop_d = bus.go;
        if (bus.mcu_done && last_s) begin
          fd_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else if (bus.mcu_done) begin
          if (x_q == cols_q) begin
            x_d = M_ZERO;
            y_d = y_q + M_ONE;
          end else begin
            x_d = x_q + M_ONE;
          end
`ifdef JPEG_RESTART_EN
          // Restart interval counts completed MCUs; a marker never follows the last one.
          if ((ri_q != R_ZERO) && ((cnt_q + R_ONE) == ri_q)) begin
            cnt_d      = R_ZERO;
            rstm_req_d = 1'b1;
            state_d    = RSTM;
          end else begin
            cnt_d   = cnt_q + R_ONE;
            req_d   = 1'b1;
            state_d = ISSUE;
          end
`else
          req_d   = 1'b1;
          state_d = ISSUE;
`endif
        end else begin
          state_d = WAIT_DONE;
        end
      end
`ifdef JPEG_RESTART_EN
      RSTM: begin
        busy_d = 1'b1;
        drop_d = bus.go;
        if (bus.rstm_ack) begin
          rstm_idx_d = rstm_idx_q + 3'd1;
          req_d      = 1'b1;
          state_d    = ISSUE;
        end else begin
          rstm_req_d = 1'b1;
        end
      end
`endif
      FINISH: begin
        drop_d  = bus.go;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cols_q  <= M_ZERO;
      rows_q  <= M_ZERO;
      x_q     <= M_ZERO;
      y_q     <= M_ZERO;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      drop_q  <= 1'b0;
`ifdef JPEG_RESTART_EN
      ri_q       <= R_ZERO;
      cnt_q      <= R_ZERO;
      rstm_req_q <= 1'b0;
      rstm_idx_q <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      drop_q  <= drop_d;
`ifdef JPEG_RESTART_EN
      ri_q       <= ri_d;
      cnt_q      <= cnt_d;
      rstm_req_q <= rstm_req_d;
      rstm_idx_q <= rstm_idx_d;
`endif
    end
  end

  assign bus.mcu_req    = req_q;
  assign bus.mcu_x      = x_q;
  assign bus.mcu_y      = y_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
  assign bus.go_drop    = drop_q;
`ifdef JPEG_RESTART_EN
  assign bus.rstm_req   = rstm_req_q;
  assign bus.rstm_idx   = rstm_idx_q;
`endif

endmodule

// File: tb/tb_jpeg_mcu_sequencer.sv
// Directed bench for jpeg_mcu_sequencer: expected MCU coordinates are queued at go and
// popped on each observed request. Restart-marker steps run only with JPEG_RESTART_EN.
module tb_jpeg_mcu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_mcu_sequencer_if bif ();

  jpeg_mcu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int hs_cnt   = 0;
  int ri_tb    = 0;
  logic [15:0] exp_q[$];

  // Handshake and frame_done pulse counters, sampled on the active edge where inputs are stable.
  always @(posedge clk) begin
    if (!rst && bif.mcu_req && bif.mcu_ack) hs_cnt++;
    if (!rst && bif.frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bif.mcu_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input int cols, input int rows);
    bif.go       = 1'b1;
    bif.mcu_cols = cols[7:0];
    bif.mcu_rows = rows[7:0];
`ifdef JPEG_RESTART_EN
    bif.ri = ri_tb[15:0];
`endif
    for (int y = 0; y <= rows; y++)
      for (int x = 0; x <= cols; x++)
        exp_q.push_back({y[7:0], x[7:0]});
    @(negedge clk);
    bif.go = 1'b0;
    chk("req_after_go", bif.mcu_req, 1);
    chk("busy_after_go", bif.busy, 1);
  endtask

  task automatic serve_mcu(input int ack_dly, input int done_dly, input bit early_done,
                           input bit is_last, input bit marker, input int midx);
    bit ok;
    logic [15:0] e;
    wait_req(ok);
    chk("req_timeout", ok, 1);
    if (!ok) return;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    chk("mcu_x", bif.mcu_x, e[7:0]);
    chk("mcu_y", bif.mcu_y, e[15:8]);
    for (int i = 0; i < ack_dly; i++) begin
      bif.mcu_done = early_done && (i == 0);
      @(negedge clk);
      chk("req_held", bif.mcu_req, 1);
      chk("x_held", {bif.mcu_y, bif.mcu_x}, e);
    end
    bif.mcu_done = 1'b0;
    bif.mcu_ack  = 1'b1;
    @(negedge clk);
    bif.mcu_ack = 1'b0;
    chk("req_drop", bif.mcu_req, 0);
    for (int i = 0; i < done_dly; i++) @(negedge clk);
    bif.mcu_done = 1'b1;
    @(negedge clk);
    bif.mcu_done = 1'b0;
    if (is_last) begin
      chk("frame_done", bif.frame_done, 1);
      chk("busy_in_fd", bif.busy, 0);
`ifdef JPEG_RESTART_EN
      chk("no_last_rstm", bif.rstm_req, 0);
`endif
    end else begin
      chk("no_early_fd", bif.frame_done, 0);
`ifdef JPEG_RESTART_EN
      chk("rstm_req", bif.rstm_req, {31'd0, marker});
      if (marker) begin
        chk("rstm_idx", bif.rstm_idx, midx[2:0]);
        chk("req_in_rstm", bif.mcu_req, 0);
        bif.rstm_ack = 1'b1;
        @(negedge clk);
        bif.rstm_ack = 1'b0;
        chk("rstm_req_drop", bif.rstm_req, 0);
      end
`endif
    end
  endtask

  task automatic run_frame(input int cols, input int rows, input int ack_dly, input int done_dly,
                           input bit early_done, input bit mid_go, input bit fin_go);
    int n, hs0, fd0, mk;
    bit marker;
    n   = (cols + 1) * (rows + 1);
    hs0 = hs_cnt;
    fd0 = fd_cnt;
    mk  = 0;
    start_frame(cols, rows);
    if (mid_go) begin
      bif.go       = 1'b1;
      bif.mcu_cols = 8'd5;
      bif.mcu_rows = 8'd5;
      @(negedge clk);
      bif.go = 1'b0;
      chk("go_drop_mid", bif.go_drop, 1);
      chk("req_after_drop", bif.mcu_req, 1);
    end
    for (int k = 0; k < n; k++) begin
      marker = (ri_tb != 0) && (((k + 1) % ri_tb) == 0) && (k != n - 1);
      serve_mcu(ack_dly, done_dly, early_done, k == n - 1, marker, mk);
      if (marker) mk++;
    end
    if (fin_go) begin
      bif.go       = 1'b1;
      bif.mcu_cols = 8'd7;
      @(negedge clk);
      bif.go = 1'b0;
      chk("go_drop_fin", bif.go_drop, 1);
      chk("idle_after_fin", {bif.busy, bif.mcu_req}, 0);
    end else begin
      @(negedge clk);
      chk("fd_one_cycle", bif.frame_done, 0);
      chk("no_drop", bif.go_drop, 0);
    end
    chk("handshakes", hs_cnt - hs0, n);
    chk("fd_count", fd_cnt - fd0, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int fd_before;
    bif.go = 1'b0; bif.mcu_cols = 8'd0; bif.mcu_rows = 8'd0;
    bif.mcu_ack = 1'b0; bif.mcu_done = 1'b0;
`ifdef JPEG_RESTART_EN
    bif.ri = 16'd0; bif.rstm_ack = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bif.mcu_req, bif.busy, bif.frame_done, bif.go_drop, bif.mcu_x, bif.mcu_y}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2x2 frame, ack in the first request cycle, done 3 cycles after ack
    run_frame(1, 1, 0, 2, 1'b0, 1'b0, 1'b0);
    // single-MCU frame
    run_frame(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // delayed ack with a premature done that must be ignored
    run_frame(2, 0, 5, 1, 1'b1, 1'b0, 1'b0);
    // go dropped mid-frame and in the frame_done cycle
    run_frame(1, 0, 1, 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("drop_one_cycle", bif.go_drop, 0);

    // reset after the second ack of a 3x2 frame
    fd_before = fd_cnt;
    start_frame(2, 1);
    serve_mcu(0, 1, 1'b0, 1'b0, 1'b0, 0);
    bif.mcu_ack = 1'b1;
    @(negedge clk);
    bif.mcu_ack = 1'b0;
    chk("x_before_rst", bif.mcu_x, 1);
    rst = 1'b1;
    #1;
    chk("rst_outputs", {bif.mcu_req, bif.busy, bif.frame_done, bif.go_drop, bif.mcu_x, bif.mcu_y}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("no_fd_after_rst", fd_cnt - fd_before, 0);
    run_frame(1, 0, 0, 1, 1'b0, 1'b0, 1'b0);

`ifdef JPEG_RESTART_EN
    ri_tb = 2;
    run_frame(2, 1, 0, 1, 1'b0, 1'b0, 1'b0);
    ri_tb = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
